ofifo_drain_ctrl: RTL and testbench

Sequencer that drains completed partial-sum rows from the output FIFO (`ofifo`) into the psum SRAM. On `start` it pops `len` rows from the FIFO one at a time and writes each to consecutive SRAM addresses from `base_addr`. In accumulate mode it instead adds each row lane-wise to the word already stored at that address. It sits between the MAC array's `ofifo` and the psum SRAM, under the top-level core controller.

---
 rtl/ofifo_drain_ctrl.sv | 134 +++++++++++++
 tb/tb_ofifo_drain_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ofifo_drain_ctrl.sv
// Drains completed partial-sum rows from the output FIFO into consecutive psum SRAM words.
// Optional feature macro: OFIFO_DRAIN_ACCUM_EN adds read-modify-write accumulation (acc=1 jobs).
module ofifo_drain_ctrl #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_w  = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [addr_w-1:0]      len,
  input  logic [addr_w-1:0]      base_addr,
  input  logic                   acc,
  input  logic                   ofifo_valid,
  input  logic [col*psum_bw-1:0] ofifo_out,
  output logic                   ofifo_rd,
  output logic                   sram_cen,
  output logic                   sram_wen,
  output logic [addr_w-1:0]      sram_a,
  output logic [col*psum_bw-1:0] sram_d,
  input  logic [col*psum_bw-1:0] sram_q,
  output logic                   busy,
  output logic                   done
);
  localparam int row_w = col * psum_bw;
  localparam logic [addr_w-1:0] one_a = addr_w'(1);

  typedef enum logic [2:0] {IDLE, CHECK, POPWAIT, MEMRD, WRITE, DONE} state_t;
  state_t state_reg, state_next;

  logic [addr_w-1:0] addr_reg, cnt_reg;
  logic [row_w-1:0]  r_reg, sram_d_reg, sram_d_next;
  logic [addr_w-1:0] sram_a_next;
  logic              ofifo_rd_next, sram_cen_next, sram_wen_next, busy_next, done_next;
  logic              acc_mode, job_load;

  assign job_load = (state_reg == IDLE) && start;

`ifdef OFIFO_DRAIN_ACCUM_EN
  logic             acc_reg;
  logic [row_w-1:0] sum_row;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        acc_reg <= 1'b0;
    else if (job_load) acc_reg <= acc;
  end
  assign acc_mode = acc_reg;

  for (genvar gi = 0; gi < col; gi++) begin : g_lane
    assign sum_row[gi*psum_bw +: psum_bw] = r_reg[gi*psum_bw +: psum_bw] + sram_q[gi*psum_bw +: psum_bw];
  end

  // sram_q only arrives during WRITE, so the sum bypasses the data register for that cycle
  assign sram_d = ((state_reg == WRITE) && acc_mode) ? sum_row : sram_d_reg;
`else
  logic unused_inputs;
  assign unused_inputs = ^{acc, sram_q};
  assign acc_mode      = 1'b0;
  assign sram_d        = sram_d_reg;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_reg <= '0;
      cnt_reg  <= '0;
      r_reg    <= '0;
    end else begin
      if (job_load && (len != '0)) begin
        addr_reg <= base_addr;
        cnt_reg  <= len;
      end else if (state_reg == WRITE) begin
        addr_reg <= addr_reg + one_a;
        cnt_reg  <= cnt_reg - one_a;
      end
      if ((state_reg == CHECK) && ofifo_valid) r_reg <= ofifo_out;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (len == '0) ? DONE : CHECK;
      CHECK:   if (ofifo_valid) state_next = POPWAIT;
      POPWAIT: state_next = acc_mode ? MEMRD : WRITE;
`ifdef OFIFO_DRAIN_ACCUM_EN
      MEMRD:   state_next = WRITE;
`endif
      WRITE:   state_next = (cnt_reg == one_a) ? DONE : CHECK;
      // a zero-length job idles one silent cycle here so done lands two cycles after start
      DONE:    state_next = done ? IDLE : DONE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_comb begin
    ofifo_rd_next = (state_next == POPWAIT);
    sram_cen_next = !((state_next == MEMRD) || (state_next == WRITE));
    sram_wen_next = (state_next != WRITE);
    sram_a_next   = sram_cen_next ? sram_a : addr_reg;
    sram_d_next   = sram_d_reg;
    if ((state_reg == POPWAIT) && (state_next == WRITE)) sram_d_next = r_reg;
`ifdef OFIFO_DRAIN_ACCUM_EN
    if ((state_reg == WRITE) && acc_mode) sram_d_next = sum_row;
`endif
    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE) && (state_reg != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ofifo_rd   <= 1'b0;
      sram_cen   <= 1'b1;
      sram_wen   <= 1'b1;
      sram_a     <= '0;
      sram_d_reg <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      ofifo_rd   <= ofifo_rd_next;
      sram_cen   <= sram_cen_next;
      sram_wen   <= sram_wen_next;
      sram_a     <= sram_a_next;
      sram_d_reg <= sram_d_next;
      busy       <= busy_next;
      done       <= done_next;
    end
  end
endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// Self-checking bench for ofifo_drain_ctrl: directed job table, reset-abort sequence and random jobs
// against a row-list model of the FIFO and SRAM contents.
module tb_ofifo_drain_ctrl;
  localparam int COL = 8, BW = 16, AW = 11, RW = COL * BW;
`ifdef OFIFO_DRAIN_ACCUM_EN
  localparam bit ACC_BUILD = 1'b1;
`else
  localparam bit ACC_BUILD = 1'b0;
`endif

  logic          clk = 1'b0, reset = 1'b0, start = 1'b0, acc = 1'b0, ofifo_valid = 1'b0;
  logic [AW-1:0] len = '0, base_addr = '0;
  logic [RW-1:0] ofifo_out = '0, sram_q;
  logic          ofifo_rd, sram_cen, sram_wen, busy, done;
  logic [AW-1:0] sram_a;
  logic [RW-1:0] sram_d;

  ofifo_drain_ctrl #(.col(COL), .psum_bw(BW), .addr_w(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .base_addr(base_addr), .acc(acc),
    .ofifo_valid(ofifo_valid), .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a), .sram_d(sram_d),
    .sram_q(sram_q), .busy(busy), .done(done));

  always #5 clk = ~clk;

  // SRAM with registered read; the pre_* port lets the bench preload words
  logic [RW-1:0] mem [0:2047];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [RW-1:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else begin
      if (!sram_cen && sram_wen)  sram_q <= mem[sram_a];
      if (!sram_cen && !sram_wen) mem[sram_a] <= sram_d;
    end
  end

  // reference state
  logic [RW-1:0] exp_mem [0:2047];
  logic [RW-1:0] fifo[$];
  logic [RW-1:0] job_rows[$];
  bit pend, rand_gate;
  int pops, stall_row, stall_cyc, stall_left;
  int n_checks = 0, n_pass = 0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One negedge step; the FIFO pops one cycle after it registers ofifo_rd.
  task automatic tick();
    @(negedge clk);
    if (pend && fifo.size() > 0) begin
      fifo.delete(0);
      pops++;
      if (pops == stall_row) stall_left = stall_cyc + 1;
    end
    pend = ofifo_rd;
    if (stall_left > 0) begin
      ofifo_valid = 1'b0;
      stall_left--;
    end else begin
      ofifo_valid = (fifo.size() > 0) && (!rand_gate || $urandom_range(3) != 0);
    end
    ofifo_out = (fifo.size() > 0) ? fifo[0] : '0;
  endtask

  task automatic preload(input int a, input logic [RW-1:0] d);
    pre_we = 1'b1; pre_addr = AW'(a); pre_data = d;
    tick();
    pre_we = 1'b0;
    exp_mem[AW'(a)] = d;
  endtask

  function automatic logic [RW-1:0] pat_row(input int n);
    logic [RW-1:0] r;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = 16'(((n & 15) << 8) | i);
    return r;
  endfunction

  task automatic run_job(input string tag, input int jlen, input int jbase, input bit jacc,
                         input int srow, input int scyc, input int restart_t, input int exp_done);
    int done_t = -1, rd_n = 0, mem_n = 0, wr_n = 0;
    bit consec = 1'b0, prev_rd = 1'b0, busy1 = 1'b0, do_acc;
    logic [AW-1:0] ea[$];
    logic [RW-1:0] ed[$];
    logic [AW-1:0] a;
    logic [RW-1:0] d;
    do_acc = jacc && ACC_BUILD;
    for (int n = 0; n < jlen; n++) begin
      a = AW'(jbase + n);
      d = job_rows[n];
      if (do_acc)
        for (int l = 0; l < COL; l++) d[l*BW +: BW] = exp_mem[a][l*BW +: BW] + job_rows[n][l*BW +: BW];
      exp_mem[a] = d;
      ea.push_back(a);
      ed.push_back(d);
      fifo.push_back(job_rows[n]);
    end
    pops = 0; stall_row = srow; stall_cyc = scyc; stall_left = 0;
    tick();
    start = 1'b1; len = AW'(jlen); base_addr = AW'(jbase); acc = jacc;
    for (int t = 1; t <= 400 && done_t < 0; t++) begin
      tick();
      start = (t == restart_t);
      if (start) begin len = 7; base_addr = 500; acc = !jacc; end
      if (t == 1) busy1 = busy;
      if (ofifo_rd) begin rd_n++; if (prev_rd) consec = 1'b1; end
      prev_rd = ofifo_rd;
      if (!sram_cen) mem_n++;
      if (!sram_cen && !sram_wen) begin
        if (wr_n < ea.size()) begin
          chk({tag, "_wr_addr"}, RW'(sram_a), RW'(ea[wr_n]));
          chk({tag, "_wr_data"}, sram_d, ed[wr_n]);
        end
        wr_n++;
      end
      if (done) done_t = t;
    end
    start = 1'b0;
    chk({tag, "_busy_c1"}, RW'(busy1), RW'(1));
    chk({tag, "_done_seen"}, RW'(done_t >= 0), RW'(1));
    if (exp_done > 0) chk({tag, "_done_cycle"}, RW'(done_t), RW'(exp_done));
    chk({tag, "_rd_pulses"}, RW'(rd_n), RW'(jlen));
    chk({tag, "_writes"}, RW'(wr_n), RW'(jlen));
    chk({tag, "_sram_cycles"}, RW'(mem_n), RW'(do_acc ? 2 * jlen : jlen));
    chk({tag, "_rd_back2back"}, RW'(consec), RW'(0));
    tick();
    chk({tag, "_done_1cyc"}, RW'(done), RW'(0));
    chk({tag, "_busy_after"}, RW'(busy), RW'(0));
    $display("job %s len=%0d base=%0d acc=%0d done_at=%0d rd=%0d writes=%0d",
             tag, jlen, jbase, jacc, done_t, rd_n, wr_n);
  endtask

  typedef struct {
    int len; int base; bit acc; bit ones; int stall_row; int stall_cyc; int restart_t; int exp_done;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int rc, rdn, saw_done;
    logic [RW-1:0] ones_row, sat_row;
    rc = ACC_BUILD ? 4 : 3;
    for (int l = 0; l < COL; l++) begin ones_row[l*BW +: BW] = 16'h0001; sat_row[l*BW +: BW] = 16'h7FFF; end
    vecs[0] = '{4,  10,   0, 0, 0, 0, 0, 13};
    vecs[1] = '{4,  20,   0, 0, 2, 5, 0, 18};
    vecs[2] = '{0,  30,   0, 0, 0, 0, 0, 2};
    vecs[3] = '{3,  2046, 0, 0, 0, 0, 0, 10};
    vecs[4] = '{3,  100,  0, 0, 0, 0, 4, 10};
    vecs[5] = '{1,  7,    1, 0, 0, 0, 0, rc + 1};
    vecs[6] = '{2,  300,  1, 1, 0, 0, 3, 2 * rc + 1};

    // reset state
    tick();
    chk("rst_ofifo_rd", RW'(ofifo_rd), RW'(0));
    chk("rst_cen", RW'(sram_cen), RW'(1));
    chk("rst_wen", RW'(sram_wen), RW'(1));
    chk("rst_busy", RW'(busy), RW'(0));
    chk("rst_done", RW'(done), RW'(0));
    reset = 1'b1;
    tick(); tick();

    if (ACC_BUILD)
      for (int a = 0; a < 2048; a++) preload(a, {$urandom, $urandom, $urandom, $urandom});

    for (int v = 0; v < 7; v++) begin
      job_rows.delete();
      for (int n = 0; n < vecs[v].len; n++) job_rows.push_back(vecs[v].ones ? ones_row : pat_row(n));
      if (vecs[v].acc)
        for (int n = 0; n < vecs[v].len; n++) preload(vecs[v].base + n, sat_row);
      run_job($sformatf("vec%0d", v), vecs[v].len, vecs[v].base, vecs[v].acc,
              vecs[v].stall_row, vecs[v].stall_cyc, vecs[v].restart_t, vecs[v].exp_done);
    end

    // reset abandons a job at row 2 of 4
    job_rows.delete();
    for (int n = 0; n < 4; n++) fifo.push_back(pat_row(n));
    pops = 0; stall_row = 0; stall_left = 0;
    tick();
    start = 1'b1; len = 4; base_addr = 5; acc = 1'b0;
    rdn = 0;
    for (int k = 0; k < 50 && rdn < 2; k++) begin
      tick();
      start = 1'b0;
      if (ofifo_rd) rdn++;
    end
    chk("abort_reach_row2", RW'(rdn), RW'(2));
    exp_mem[5] = pat_row(0);
    #2 reset = 1'b0;
    #1;
    chk("abort_ofifo_rd", RW'(ofifo_rd), RW'(0));
    chk("abort_cen", RW'(sram_cen), RW'(1));
    chk("abort_wen", RW'(sram_wen), RW'(1));
    chk("abort_a", RW'(sram_a), RW'(0));
    chk("abort_d", sram_d, RW'(0));
    chk("abort_busy", RW'(busy), RW'(0));
    chk("abort_done", RW'(done), RW'(0));
    saw_done = 0;
    for (int k = 0; k < 3; k++) begin tick(); if (done) saw_done++; end
    reset = 1'b1;
    fifo.delete(); pend = 1'b0;
    for (int k = 0; k < 3; k++) begin tick(); if (done) saw_done++; end
    chk("abort_no_done", RW'(saw_done), RW'(0));
    job_rows.delete();
    for (int n = 0; n < 2; n++) job_rows.push_back(pat_row(n + 5));
    run_job("after_rst", 2, 40, 1'b0, 0, 0, 0, 7);

    // random jobs with a gappy FIFO valid
    rand_gate = 1'b1;
    for (int j = 0; j < 12; j++) begin
      int jl, jb;
      bit ja;
      jl = $urandom_range(6);
      jb = $urandom_range(2047);
      ja = 1'($urandom_range(1));
      job_rows.delete();
      for (int n = 0; n < jl; n++) job_rows.push_back({$urandom, $urandom, $urandom, $urandom});
      run_job($sformatf("rnd%0d", j), jl, jb, ja, 0, 0, 0, -1);
      for (int k = 0; k < int'($urandom_range(3)); k++) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
